// File: rtl/module_detector_sindrome.sv
// module_detector_sindrome: two-stage SECDED syndrome detector with optional saturating error counters.
// Ports: clk, rst (async, active-high); datos_in[7:0]/valido_in receive a word;
// limpiar clears the counters; datos_out/sindrome/paridad_global feed the corrector;
// valido_out pulses once per word together with error_simple/error_doble;
// cuenta_simple/cuenta_doble are the error tallies.
// Macro DETECTOR_CONTADORES_EN builds the counters; otherwise they read 0.
module module_detector_sindrome #(
    parameter int ANCHO_CONTADOR = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                datos_in,
    input  logic                      valido_in,
    input  logic                      limpiar,
    output logic [7:0]                datos_out,
    output logic [2:0]                sindrome,
    output logic                      paridad_global,
    output logic                      valido_out,
    output logic                      error_simple,
    output logic                      error_doble,
    output logic [ANCHO_CONTADOR-1:0] cuenta_simple,
    output logic [ANCHO_CONTADOR-1:0] cuenta_doble
);
    logic [7:0] s1_datos;
    logic       s1_valido;
    logic [2:0] sind;
    logic       par;
    logic       simple;
    logic       doble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_datos  <= '0;
            s1_valido <= 1'b0;
        end else begin
            s1_valido <= valido_in;
            if (valido_in) s1_datos <= datos_in;
        end
    end

    // Masks select the bits covered by s4 (3,4,5,6), s2 (1,2,5,6) and s1 (0,2,4,6).
    // Any global parity mismatch is a single error: either the syndrome locates it
    // or, with a zero syndrome, it sits in the parity bit itself.
    always_comb begin
        sind   = {^(s1_datos & 8'h78), ^(s1_datos & 8'h66), ^(s1_datos & 8'h55)};
        par    = ^s1_datos;
        simple = par;
        doble  = !par && (sind != 3'b000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            datos_out      <= '0;
            sindrome       <= '0;
            paridad_global <= 1'b0;
            valido_out     <= 1'b0;
            error_simple   <= 1'b0;
            error_doble    <= 1'b0;
        end else begin
            valido_out <= s1_valido;
            if (s1_valido) begin
                datos_out      <= s1_datos;
                sindrome       <= sind;
                paridad_global <= par;
                error_simple   <= simple;
                error_doble    <= doble;
            end
        end
    end

`ifdef DETECTOR_CONTADORES_EN
    localparam logic [ANCHO_CONTADOR-1:0] cuenta_uno = 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta_simple <= '0;
            cuenta_doble  <= '0;
        end else if (limpiar) begin
            cuenta_simple <= '0;
            cuenta_doble  <= '0;
        end else if (s1_valido) begin
            if (simple && cuenta_simple != '1) cuenta_simple <= cuenta_simple + cuenta_uno;
            if (doble && cuenta_doble != '1) cuenta_doble <= cuenta_doble + cuenta_uno;
        end
    end
`else
    logic unused_limpiar;
    assign unused_limpiar = limpiar;
    assign cuenta_simple  = '0;
    assign cuenta_doble   = '0;
`endif
endmodule

// File: tb/tb_module_detector_sindrome.sv
// tb_module_detector_sindrome: scoreboard bench for the SECDED syndrome detector.
module tb_module_detector_sindrome;
    localparam int W = 2;
`ifdef DETECTOR_CONTADORES_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   datos_in = '0;
    logic         valido_in = 1'b0;
    logic         limpiar = 1'b0;
    logic [7:0]   datos_out;
    logic [2:0]   sindrome;
    logic         paridad_global;
    logic         valido_out;
    logic         error_simple;
    logic         error_doble;
    logic [W-1:0] cuenta_simple;
    logic [W-1:0] cuenta_doble;

    module_detector_sindrome #(.ANCHO_CONTADOR(W)) dut (
        .clk(clk), .rst(rst), .datos_in(datos_in), .valido_in(valido_in), .limpiar(limpiar),
        .datos_out(datos_out), .sindrome(sindrome), .paridad_global(paridad_global),
        .valido_out(valido_out), .error_simple(error_simple), .error_doble(error_doble),
        .cuenta_simple(cuenta_simple), .cuenta_doble(cuenta_doble)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic       p;
        logic       es;
        logic       ed;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic         lim_q = 1'b0;
    logic [W-1:0] cs_m = '0;
    logic [W-1:0] cd_m = '0;

    function automatic exp_t model(input logic [7:0] w);
        exp_t e;
        e.d = w;
        e.s = 3'b000;
        for (int i = 0; i < 7; i++) if (w[i]) e.s = e.s ^ 3'(i + 1);
        e.p = ^w;
        e.es = 1'b0;
        e.ed = 1'b0;
        if (e.s == 3'b000 && !e.p) begin
            e.es = 1'b0;
        end else if (e.p) begin
            e.es = 1'b1;
        end else begin
            e.ed = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c, input logic en);
        return (!en || c == {W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always @(posedge clk) lim_q <= limpiar;

    always @(negedge clk) begin
        if (rst) begin
            cs_m = '0;
            cd_m = '0;
        end else if (valido_out) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected valido_out=1 datos_out=%h required no output", datos_out);
            end else begin
                e = sb.pop_front();
                if ({datos_out, sindrome, paridad_global, error_simple, error_doble} !== {e.d, e.s, e.p, e.es, e.ed}) begin
                    failures++;
                    $display("FAIL sb_word got d=%h s=%b p=%b es=%b ed=%b required d=%h s=%b p=%b es=%b ed=%b",
                             datos_out, sindrome, paridad_global, error_simple, error_doble, e.d, e.s, e.p, e.es, e.ed);
                end
                cs_m = lim_q ? '0 : sat_inc(cs_m, e.es);
                cd_m = lim_q ? '0 : sat_inc(cd_m, e.ed);
            end
            checks++;
            if ({cuenta_simple, cuenta_doble} !== (CNT_EN ? {cs_m, cd_m} : '0)) begin
                failures++;
                $display("FAIL sb_counters got simple=%0d doble=%0d required simple=%0d doble=%0d",
                         cuenta_simple, cuenta_doble, CNT_EN ? cs_m : '0, CNT_EN ? cd_m : '0);
            end
        end else if (lim_q) begin
            cs_m = '0;
            cd_m = '0;
        end
    end

    task automatic send(input logic [7:0] w);
        @(posedge clk);
        #1;
        datos_in = w;
        valido_in = 1'b1;
        sb.push_back(model(w));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valido_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({datos_out, sindrome, paridad_global, valido_out, error_simple, error_doble, cuenta_simple, cuenta_doble} !== '0) begin
            failures++;
            $display("FAIL reset_values got d=%h s=%b p=%b v=%b es=%b ed=%b cs=%0d cd=%0d required all 0",
                     datos_out, sindrome, paridad_global, valido_out, error_simple, error_doble, cuenta_simple, cuenta_doble);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int n = 0;
        send(8'h4B);
        idle();
        @(posedge clk);
        #1;
        checks++;
        if (valido_out !== 1'b1 || datos_out !== 8'h4B) begin
            failures++;
            $display("FAIL latency got v=%b d=%h required v=1 d=4b two edges after sample", valido_out, datos_out);
        end
        wait_drain("latency");
    endtask

    task automatic test_patterns();
        send(8'h4F);
        send(8'hCB);
        send(8'h48);
        idle();
        wait_drain("patterns");
        checks++;
        if ({cuenta_simple, cuenta_doble} !== (CNT_EN ? {2'd2, 2'd1} : '0)) begin
            failures++;
            $display("FAIL pattern_counts got simple=%0d doble=%0d", cuenta_simple, cuenta_doble);
        end
    endtask

    task automatic test_saturation();
        @(posedge clk);
        #1;
        limpiar = 1'b1;
        @(posedge clk);
        #1;
        limpiar = 1'b0;
        repeat (5) send(8'h4F);
        idle();
        wait_drain("saturation");
        checks++;
        if (cuenta_simple !== (CNT_EN ? 2'd3 : 2'd0)) begin
            failures++;
            $display("FAIL saturation got %0d required %0d", cuenta_simple, CNT_EN ? 3 : 0);
        end
        send(8'h4F);
        @(posedge clk);
        #1;
        valido_in = 1'b0;
        limpiar = 1'b1;
        @(posedge clk);
        #1;
        limpiar = 1'b0;
        checks++;
        if (cuenta_simple !== 2'd0) begin
            failures++;
            $display("FAIL clear_priority got %0d required 0", cuenta_simple);
        end
        wait_drain("clear");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        wait_drain("random");
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send(8'h4F);
        @(posedge clk);
        #1;
        valido_in = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({datos_out, sindrome, paridad_global, valido_out, error_simple, error_doble, cuenta_simple, cuenta_doble} !== '0) begin
            failures++;
            $display("FAIL reset_mid_values got d=%h s=%b p=%b v=%b cs=%0d required all 0",
                     datos_out, sindrome, paridad_global, valido_out, cuenta_simple);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valido_out) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_flush got %0d valido_out pulses required 0", seen);
        end
        send(8'hCB);
        idle();
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/module_detector_sindrome.md
# module_detector_sindrome

Upstream stage of the SECDED receive path: registers each received 8-bit Hamming(7,4)+global-parity word, computes the 3-bit syndrome and global-parity flag in a two-stage pipeline, and classifies each word as no error, single (correctable) error or double (uncorrectable) error. Its word, syndrome and parity outputs drive `module_corrector_error` directly. Optional saturating counters tally single and double errors for LED/display reporting.

## Interface
- `ANCHO_CONTADOR`, default 8: width of each error counter.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `datos_in`  input  8  received word. Bit i (i = 0..6) is Hamming position i+1 (p1 p2 d1 p4 d2 d3 d4); bit 7 is global even parity.
- `valido_in`  input  1  `datos_in` is valid this cycle; one word is accepted per high cycle; no backpressure.
- `limpiar`  input  1  synchronous clear of both counters.
- `datos_out`  output  8  received word, unmodified; goes to the corrector's `datos_recibidos`.
- `sindrome`  output  3  {s4,s2,s1}; goes to the corrector's `sindrome`.
- `paridad_global`  output  1  XOR of all 8 received bits; 1 means parity mismatch.
- `valido_out`  output  1  outputs above carry a new result this cycle; one-cycle pulse per accepted word.
- `error_simple`  output  1  classification, valid with `valido_out`.
- `error_doble`  output  1  classification, valid with `valido_out`.
- `cuenta_simple`  output  ANCHO_CONTADOR  saturating count of single errors.
- `cuenta_doble`  output  ANCHO_CONTADOR  saturating count of double errors.

## Operation
- Stage 1: when `valido_in` is high, capture `datos_in` into the stage-1 register and set the stage-1 valid bit. When `valido_in` is low, clear the valid bit and hold the data.
- Stage 2: when the stage-1 valid bit is set, register the word, syndrome, parity and classification, and pulse `valido_out`.
- Syndrome equations, by bit index:
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s4 = b3^b4^b5^b6
  - A nonzero syndrome s points to bit index s−1.
- Classification, with S = `sindrome` and P = `paridad_global`:
  - S=0, P=0: no error; both flags 0.
  - S≠0, P=1: `error_simple`.
  - S=0, P=1: `error_simple`; the error is in bit 7.
  - S≠0, P=0: `error_doble`.
  - `error_simple` and `error_doble` are never both 1.
- Outputs hold their last value while `valido_out` is low. Flags are meaningful only when `valido_out` is high.
- Counters increment on the edge that asserts `valido_out` with the matching flag. Each saturates at 2^ANCHO_CONTADOR−1 and never wraps.
- When `limpiar` and an increment occur in the same cycle, `limpiar` wins and the counter goes to 0.

## Timing
- Latency is 2 cycles: a word sampled on edge k appears with `valido_out`=1 after edge k+1.
- Throughput is 1 word per cycle. Back-to-back `valido_in` gives back-to-back `valido_out`.
- Reset (asynchronous): `datos_out`=8'h00, `sindrome`=3'b000, `paridad_global`=0, `valido_out`=0, both flags 0, both counters 0, both pipeline valid bits 0.
- Reset asserted mid-pipeline flushes in-flight words. No `valido_out` is produced for them after reset is released.
- The first `valido_in` sampled after release produces output 2 cycles later.
- The stage-1 to stage-2 path is combinational syndrome logic only. No multicycle paths.

## Configuration
- `DETECTOR_CONTADORES_EN` defined: counters and `limpiar` logic are built as described above.
- Not defined: no counter registers are built. `cuenta_simple` and `cuenta_doble` are tied to 0 and `limpiar` is ignored. Pipeline behaviour and classification are identical in both builds.

## Test plan
- Clean word, the encoding of data 0001: `datos_in`=8'h4B, `valido_in` pulse → 2 cycles later `valido_out`=1, `sindrome`=000, `paridad_global`=0, both flags 0, `datos_out`=8'h4B.
- Single data error: 8'h4F (bit 2 flipped) → `sindrome`=011, `paridad_global`=1, `error_simple`=1, `cuenta_simple`=1.
- Parity-bit error: 8'hCB → `sindrome`=000, `paridad_global`=1, `error_simple`=1.
- Double error: 8'h48 (bits 0 and 1 flipped) → `sindrome`=011, `paridad_global`=0, `error_doble`=1, `cuenta_doble`=1.
- Streaming and saturation, with ANCHO_CONTADOR=2: 5 consecutive 8'h4F words with `valido_in` held high → 5 consecutive `valido_out` pulses, and `cuenta_simple` reads 1, 2, 3, 3, 3.
  - Then `limpiar` asserted in the same cycle as an increment → `cuenta_simple`=0.
- Reset mid-operation: assert `rst` one cycle after a `valido_in` pulse → all outputs immediately reset, and no `valido_out` is seen after release.
